// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: loadable instruction memory, program counter and a
// LOAD/RUN/HALT sequencer presenting one registered instruction per cycle.
module instr_fetch_unit #(
  parameter int                 ADDR_W    = 5,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ld_en,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [INSTR_W-1:0] ld_data,
  input  logic               start,
  input  logic               stall,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_q,
  output logic [INSTR_W-1:0] instr,
  output logic               ins_valid,
  output logic               insmsb,
  output logic [5:0]         func,
  output logic               halted,
  output logic [1:0]         state_o
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {
    S_LOAD = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_e;

  state_e             state_q;
  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]  fetch_pc_q;
  logic [ADDR_W-1:0]  cur_pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q;
  logic               halted_q;

  logic [INSTR_W-1:0] fetch_word_d;
  logic [ADDR_W-1:0]  pc_inc_d;
  logic               mem_we_d;

  assign fetch_word_d = mem_q[fetch_pc_q];
  assign pc_inc_d     = fetch_pc_q + 1'b1;
  assign mem_we_d     = reset_n && ld_en && (state_q == S_LOAD || state_q == S_HALT);

  // Memory is never reset; writes are only accepted outside RUN.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_LOAD;
      fetch_pc_q <= '0;
      cur_pc_q   <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          if (start) begin
            state_q    <= S_RUN;
            fetch_pc_q <= '0;
          end
        end
        S_RUN: begin
          // A stalled cycle neither fetches nor checks for the halt word.
          if (!stall) begin
            if (fetch_word_d == HALT_WORD) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              instr_q    <= fetch_word_d;
              cur_pc_q   <= fetch_pc_q;
              valid_q    <= 1'b1;
              fetch_pc_q <= pc_inc_d;
            end
          end
        end
        S_HALT: begin
          if (start) begin
            state_q    <= S_RUN;
            fetch_pc_q <= '0;
            halted_q   <= 1'b0;
          end else if (ld_en) begin
            state_q  <= S_LOAD;
            halted_q <= 1'b0;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign pc        = fetch_pc_q;
  assign pc_q      = cur_pc_q;
  assign instr     = instr_q;
  assign ins_valid = valid_q;
  assign insmsb    = instr_q[INSTR_W-1];
  assign func      = instr_q[5:0];
  assign halted    = halted_q;
  assign state_o   = state_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a per-cycle reference model plus directed checks,
// and a second narrow-address instance used for the pc wrap-around scenario.
module tb_instr_fetch_unit;
  localparam int DEPTH = 32;
  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, ld_en, start, stall;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic [4:0]  pc, pc_q;
  logic [31:0] instr;
  logic        ins_valid, insmsb, halted;
  logic [5:0]  func;
  logic [1:0]  state_o;

  logic        w_reset_n, w_ld_en, w_start, w_stall;
  logic [1:0]  w_ld_addr;
  logic [31:0] w_ld_data;
  logic [1:0]  w_pc, w_pc_q;
  logic [31:0] w_instr;
  logic        w_ins_valid, w_insmsb, w_halted;
  logic [5:0]  w_func;
  logic [1:0]  w_state_o;

  instr_fetch_unit #(.ADDR_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .start(start), .stall(stall), .pc(pc), .pc_q(pc_q),
    .instr(instr), .ins_valid(ins_valid), .insmsb(insmsb), .func(func),
    .halted(halted), .state_o(state_o)
  );

  instr_fetch_unit #(.ADDR_W(2)) dut_wrap (
    .clk(clk), .reset_n(w_reset_n), .ld_en(w_ld_en), .ld_addr(w_ld_addr),
    .ld_data(w_ld_data), .start(w_start), .stall(w_stall), .pc(w_pc), .pc_q(w_pc_q),
    .instr(w_instr), .ins_valid(w_ins_valid), .insmsb(w_insmsb), .func(w_func),
    .halted(w_halted), .state_o(w_state_o)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h @%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 = loading, 1 = running, 2 = halted.
  logic [31:0] m_mem [DEPTH];
  int          m_mode = 0;
  int          m_pc = 0;
  int          m_pcq = 0;
  logic [31:0] m_instr = '0;
  bit          m_valid = 0;
  bit          m_halt = 0;
  bit          m_ready = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_mode = 0; m_pc = 0; m_pcq = 0; m_instr = '0;
      m_valid = 0; m_halt = 0; m_ready = 1;
    end else if (m_mode == 1) begin
      m_valid = 0;
      if (!stall) begin
        if (m_mem[m_pc] == HALTW) begin
          m_mode = 2;
          m_halt = 1;
        end else begin
          m_instr = m_mem[m_pc];
          m_pcq   = m_pc;
          m_valid = 1;
          m_pc    = (m_pc + 1) % DEPTH;
        end
      end
    end else begin
      m_valid = 0;
      if (ld_en) m_mem[ld_addr] = ld_data;
      if (start) begin
        m_mode = 1; m_pc = 0; m_halt = 0;
      end else if (ld_en) begin
        m_mode = 0; m_halt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("model_pc",     32'(pc),        32'(m_pc[4:0]));
      chk("model_pc_q",   32'(pc_q),      32'(m_pcq[4:0]));
      chk("model_instr",  instr,          m_instr);
      chk("model_valid",  32'(ins_valid), 32'(m_valid));
      chk("model_insmsb", 32'(insmsb),    32'(m_instr[31]));
      chk("model_func",   32'(func),      32'(m_instr[5:0]));
      chk("model_halted", 32'(halted),    32'(m_halt));
      chk("model_state",  32'(state_o),   32'(m_mode[1:0]));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [4:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; ld_en = 1'b0; start = 1'b0; stall = 1'b0;
    ld_addr = '0; ld_data = '0;
    w_reset_n = 1'b0; w_ld_en = 1'b0; w_start = 1'b0; w_stall = 1'b0;
    w_ld_addr = '0; w_ld_data = '0;
    @(negedge clk);

    // Reset held two cycles
    step(); step();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", 32'(ins_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    reset_n = 1'b1;

    // Program load, run to halt
    load(5'd0, 32'h8000_0000);
    load(5'd1, 32'h0000_0030);
    load(5'd2, HALTW);
    pulse_start();
    step();
    chk("t1_instr0", instr, 32'h8000_0000);
    chk("t1_msb0", 32'(insmsb), 32'd1);
    chk("t1_func0", 32'(func), 32'd0);
    chk("t1_pcq0", 32'(pc_q), 32'd0);
    step();
    chk("t1_msb1", 32'(insmsb), 32'd0);
    chk("t1_func1", 32'(func), 32'h30);
    chk("t1_pcq1", 32'(pc_q), 32'd1);
    step();
    chk("t1_halted", 32'(halted), 32'd1);
    chk("t1_valid", 32'(ins_valid), 32'd0);
    chk("t1_pc", 32'(pc), 32'd2);
    chk("t1_instr_hold", instr, 32'h0000_0030);

    // ld_en in HALT returns to LOAD
    load(5'd0, 32'h11);
    chk("t6_ld_state", 32'(state_o), 32'd0);
    chk("t6_ld_halted", 32'(halted), 32'd0);
    load(5'd1, 32'h22);
    load(5'd2, 32'h33);
    load(5'd3, HALTW);

    // Stall for three cycles while instr=0x22
    pulse_start();
    step();
    step();
    chk("t2_pre_instr", instr, 32'h22);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_stall_instr", instr, 32'h22);
      chk("t2_stall_pcq", 32'(pc_q), 32'd1);
      chk("t2_stall_pc", 32'(pc), 32'd2);
      chk("t2_stall_valid", 32'(ins_valid), 32'd0);
    end
    stall = 1'b0;
    step();
    chk("t2_release_instr", instr, 32'h33);
    step();
    chk("t2_halted", 32'(halted), 32'd1);

    // start in HALT reruns from 0; start/ld_en in RUN ignored
    pulse_start();
    chk("t6_rerun_halted", 32'(halted), 32'd0);
    chk("t6_rerun_state", 32'(state_o), 32'd1);
    chk("t6_rerun_pc", 32'(pc), 32'd0);
    step();
    chk("t6_rerun_instr", instr, 32'h11);
    ld_en = 1'b1; ld_addr = 5'd2; ld_data = 32'hDEAD; start = 1'b1;
    step();
    ld_en = 1'b0; start = 1'b0;
    chk("t6_run_ign_pc", 32'(pc), 32'd2);
    chk("t6_run_ign_instr", instr, 32'h22);
    step();
    chk("t6_run_nowrite", instr, 32'h33);
    step();
    chk("t6_halt_again", 32'(halted), 32'd1);

    // Reset mid-RUN at pc=3
    load(5'd3, 32'h44);
    load(5'd4, 32'h55);
    pulse_start();
    step(); step(); step();
    chk("t4_pc3", 32'(pc), 32'd3);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("t4_state", 32'(state_o), 32'd0);
    chk("t4_pc", 32'(pc), 32'd0);
    chk("t4_instr", instr, 32'd0);
    chk("t4_valid", 32'(ins_valid), 32'd0);
    chk("t4_msb", 32'(insmsb), 32'd0);
    chk("t4_func", 32'(func), 32'd0);
    pulse_start();
    step();
    chk("t4_refetch", instr, 32'h11);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;

    // Simultaneous ld_en and start in LOAD
    ld_en = 1'b1; ld_addr = 5'd0; ld_data = 32'h0000_0025; start = 1'b1;
    step();
    ld_en = 1'b0; start = 1'b0;
    step();
    chk("t5_instr", instr, 32'h0000_0025);
    chk("t5_func", 32'(func), 32'h25);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;

    // Wrap-around on the 4-word instance
    step();
    w_reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_ld_en = 1'b1; w_ld_addr = 2'(i); w_ld_data = 32'hA0 + 32'(i);
      step();
    end
    w_ld_en = 1'b0;
    w_start = 1'b1;
    step();
    w_start = 1'b0;
    chk("t3_pc_start", 32'(w_pc), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t3_pcq", 32'(w_pc_q), 32'(i % 4));
      chk("t3_pc", 32'(w_pc), 32'((i + 1) % 4));
      chk("t3_instr", w_instr, 32'hA0 + 32'(i % 4));
      chk("t3_valid", 32'(w_ins_valid), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
